if_fetch: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode stage: owns the program counter, a loader-writable instruction memory, and the IF/ID pipeline register. Each advancing cycle it fetches the word at PC, selects the next PC (sequential, branch, jump, register jump), and presents instruction and PC+4 to decode. Decode takes its jump field, immediate and register addresses from `o_IFID_instruction`, and its PC+4 input from `o_IFID_PC4`. The debug unit loads the program byte-wise and single-steps the pipeline through `i_step`.

---
 rtl/if_fetch.sv | 121 ++++++++++++
 tb/tb_if_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, loader-written instruction memory, IF/ID register
module if_fetch #(
    parameter int              BITS_SIZE   = 32,
    parameter int              MEM_WORDS   = 64,
    parameter logic [BITS_SIZE-1:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_step,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic [1:0]                   i_pc_src,
    input  logic [BITS_SIZE-1:0]         i_branch_addr,
    input  logic [BITS_SIZE-1:0]         i_jump_addr,
    input  logic [BITS_SIZE-1:0]         i_jr_addr,
    input  logic                         i_load_en,
    input  logic                         i_load_valid,
    input  logic [7:0]                   i_load_byte,
    output logic [BITS_SIZE-1:0]         o_pc,
    output logic [BITS_SIZE-1:0]         o_IFID_PC4,
    output logic [BITS_SIZE-1:0]         o_IFID_instruction,
    output logic                         o_halt,
    output logic [$clog2(MEM_WORDS):0]   o_load_words
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [BITS_SIZE-1:0] mem [MEM_WORDS];

    logic [BITS_SIZE-1:0] pc;
    logic [BITS_SIZE-1:0] ifid_pc4;
    logic [BITS_SIZE-1:0] ifid_instr;
    logic                 halt;
    logic [BITS_SIZE-1:0] fetch_word;
    logic [BITS_SIZE-1:0] pc_plus4;
    logic [BITS_SIZE-1:0] next_pc;
    logic                 advance;

    logic [1:0]           byte_cnt;
    logic [23:0]          byte_buf;
    logic [AW-1:0]        wr_idx;
    logic [AW:0]          load_words;
    logic                 load_en_q;
    logic                 word_done;

    assign fetch_word = mem[pc[AW+1:2]];
    assign pc_plus4   = pc + BITS_SIZE'(4);
    assign advance    = !halt && i_step && !i_stall;
    assign word_done  = i_load_en && i_load_valid && (byte_cnt == 2'd3);

    always_comb begin
        next_pc = pc_plus4;
        case (i_pc_src)
            2'b01:   next_pc = i_branch_addr;
            2'b10:   next_pc = i_jump_addr;
            2'b11:   next_pc = i_jr_addr;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_load_en) begin
            pc         <= '0;
            ifid_pc4   <= '0;
            ifid_instr <= '0;
            halt       <= 1'b0;
        end else if (advance) begin
            ifid_pc4   <= pc_plus4;
            ifid_instr <= i_flush ? '0 : fetch_word;
            // A fetched HALT parks the PC on itself so the halt word stays addressable.
            if (!i_flush && fetch_word == HALT_OPCODE) begin
                halt <= 1'b1;
            end else begin
                pc <= next_pc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            byte_cnt   <= '0;
            byte_buf   <= '0;
            wr_idx     <= '0;
            load_words <= '0;
            load_en_q  <= 1'b0;
        end else begin
            load_en_q <= i_load_en;
            if (!i_load_en) begin
                byte_cnt <= '0;
                byte_buf <= '0;
                wr_idx   <= '0;
            end else begin
                // Entry into loader mode restarts the word count; no word can complete on that edge.
                if (!load_en_q) begin
                    load_words <= '0;
                end
                if (i_load_valid) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    byte_buf <= {byte_buf[15:0], i_load_byte};
                end
                if (word_done) begin
                    wr_idx <= wr_idx + 1'b1;
                    if (load_words != (AW+1)'(MEM_WORDS)) begin
                        load_words <= load_words + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && word_done) begin
            mem[wr_idx] <= BITS_SIZE'({byte_buf, i_load_byte});
        end
    end

    assign o_pc               = pc;
    assign o_IFID_PC4         = ifid_pc4;
    assign o_IFID_instruction = ifid_instr;
    assign o_halt             = halt;
    assign o_load_words       = load_words;
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch against a behavioural model
module tb_if_fetch;
    localparam int          MW   = 64;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] br_addr = '0, j_addr = '0, jr_addr = '0;
    logic        load_en = 1'b0, load_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic [31:0] pc, ifid_pc4, ifid_instr;
    logic        halt;
    logic [6:0]  load_words;

    if_fetch dut (
        .i_clk(clk), .i_reset(rst), .i_step(step), .i_stall(stall), .i_flush(flush),
        .i_pc_src(pc_src), .i_branch_addr(br_addr), .i_jump_addr(j_addr), .i_jr_addr(jr_addr),
        .i_load_en(load_en), .i_load_valid(load_valid), .i_load_byte(load_byte),
        .o_pc(pc), .o_IFID_PC4(ifid_pc4), .o_IFID_instruction(ifid_instr),
        .o_halt(halt), .o_load_words(load_words)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [MW];
    logic [31:0] m_pc = '0, m_pc4 = '0, m_instr = '0;
    logic        m_halt = 1'b0;
    int          m_wr = 0, m_lw = 0;
    logic        m_prev_load = 1'b0;
    logic [7:0]  m_bytes [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] w;
        if (!rst) begin
            m_pc = '0; m_pc4 = '0; m_instr = '0; m_halt = 1'b0;
            m_wr = 0; m_lw = 0; m_bytes.delete();
        end else if (load_en) begin
            m_pc = '0; m_pc4 = '0; m_instr = '0; m_halt = 1'b0;
            if (!m_prev_load) m_lw = 0;
            if (load_valid) begin
                m_bytes.push_back(load_byte);
                if (m_bytes.size() == 4) begin
                    m_mem[m_wr] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_wr = (m_wr + 1) % MW;
                    m_lw = (m_lw < MW) ? m_lw + 1 : MW;
                    m_bytes.delete();
                end
            end
        end else begin
            m_bytes.delete();
            m_wr = 0;
            if (!m_halt && step && !stall) begin
                w = m_mem[(m_pc / 4) % MW];
                m_pc4   = m_pc + 32'd4;
                m_instr = flush ? 32'h0 : w;
                if (!flush && w == HALT) m_halt = 1'b1;
                else case (pc_src)
                    2'b00: m_pc = m_pc + 32'd4;
                    2'b01: m_pc = br_addr;
                    2'b10: m_pc = j_addr;
                    default: m_pc = jr_addr;
                endcase
            end
        end
        m_prev_load = rst ? load_en : 1'b0;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check("pc", 64'(pc), 64'(m_pc));
        check("ifid_pc4", 64'(ifid_pc4), 64'(m_pc4));
        check("ifid_instr", 64'(ifid_instr), 64'(m_instr));
        check("halt", 64'(halt), 64'(m_halt));
        check("load_words", 64'(load_words), 64'(m_lw));
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1; load_byte = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    endtask

    task automatic run_mode();
        load_en = 1'b0; step = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < MW; i++) m_mem[i] = 'x;
        rst = 1'b0; step = 1'b1;
        tick(); tick();
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_instr", 64'(ifid_instr), 64'h0);
        check("rst_lw", 64'(load_words), 64'h0);
        rst = 1'b1;

        load_en = 1'b1;
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        check("lw_two", 64'(load_words), 64'd2);
        run_mode();
        tick();
        check("run1_instr", 64'(ifid_instr), 64'h2001_0005);
        check("run1_pc4", 64'(ifid_pc4), 64'd4);
        tick();
        check("run2_instr", 64'(ifid_instr), 64'hFFFF_FFFF);
        check("run2_halt", 64'(halt), 64'd1);
        check("run2_pc", 64'(pc), 64'd4);
        tick();
        check("halt_hold_pc", 64'(pc), 64'd4);

        load_en = 1'b1;
        for (int i = 0; i < MW; i++) send_word(32'h1000_0000 + 32'(i) * 4);
        run_mode();
        tick(); tick();
        check("pre_stall_pc", 64'(pc), 64'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 64'(pc), 64'd8);
            check("stall_instr", 64'(ifid_instr), 64'h1000_0004);
        end
        stall = 1'b0; step = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("nostep_pc", 64'(pc), 64'd8);
        end
        step = 1'b1;
        tick();
        check("release_pc", 64'(pc), 64'd12);

        pc_src = 2'b10; j_addr = 32'h40; flush = 1'b1;
        tick();
        check("jump_pc", 64'(pc), 64'h40);
        check("jump_flush", 64'(ifid_instr), 64'h0);
        pc_src = 2'b11; jr_addr = 32'h10;
        tick();
        check("jr_pc", 64'(pc), 64'h10);
        pc_src = 2'b00; flush = 1'b0;
        tick();
        check("seq_instr", 64'(ifid_instr), 64'h1000_0010);
        stall = 1'b1; pc_src = 2'b01; br_addr = 32'h80; flush = 1'b1;
        tick();
        check("prio_pc", 64'(pc), 64'h14);
        check("prio_instr", 64'(ifid_instr), 64'h1000_0010);
        stall = 1'b0; flush = 1'b0; pc_src = 2'b00;

        load_en = 1'b1;
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        load_en = 1'b0; step = 1'b0;
        tick();
        load_en = 1'b1;
        for (int i = 0; i <= MW; i++) send_word(32'hA000_0000 + 32'(i));
        check("lw_sat", 64'(load_words), 64'(MW));
        run_mode();
        tick();
        check("wrap_word0", 64'(ifid_instr), 64'hA000_0040);
        tick();
        check("wrap_word1", 64'(ifid_instr), 64'hA000_0001);

        load_en = 1'b1;
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        send_word(32'h5566_7788);
        run_mode();
        tick();
        check("rst_midload", 64'(ifid_instr), 64'h5566_7788);

        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 199) != 0);
            load_en    = ($urandom_range(0, 19) == 0) ? ~load_en : load_en;
            load_valid = ($urandom_range(0, 3) != 0);
            load_byte  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            step       = ($urandom_range(0, 4) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 4) == 0);
            pc_src     = 2'($urandom);
            br_addr    = $urandom;
            j_addr     = $urandom;
            jr_addr    = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
